// File: rtl/clock_frame_pkg.sv
// Shared types and frame packing for the clock-number serial link.
package clock_frame_pkg;

  localparam int FRAME_BITS = 96;

  typedef logic [3:0]       clock_num_t;
  typedef clock_num_t [11:0] clock_nums_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } tx_state_t;

  // nums[0] (1 o'clock) lands in the first byte on the wire, upper nibble zero
  function automatic logic [FRAME_BITS-1:0] pack_frame(input clock_nums_t n);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int i = 0; i < 12; i++)
      f[FRAME_BITS-1-8*i -: 8] = {4'h0, n[i]};
    return f;
  endfunction

endpackage

// File: rtl/clock_frame_tx_if.sv
// Frame request and SPI-side signals of clock_frame_tx; cs_n only under CLOCK_FRAME_TX_CS_EN.
interface clock_frame_tx_if;
  import clock_frame_pkg::*;

  logic        start;
  clock_nums_t nums;
  logic        sck;
  logic        sdo;
  logic        busy;
  logic        done;
`ifdef CLOCK_FRAME_TX_CS_EN
  logic        cs_n;
`endif

  modport master (
    input  start, nums,
`ifdef CLOCK_FRAME_TX_CS_EN
    output cs_n,
`endif
    output sck, sdo, busy, done
  );

  modport slave (
    output start, nums,
`ifdef CLOCK_FRAME_TX_CS_EN
    input  cs_n,
`endif
    input  sck, sdo, busy, done
  );

endinterface

// File: rtl/clock_frame_tx_phase.sv
// Half-period timer: counts 0..CLK_DIV-1 and strobes phase_end on the last count.
module clock_frame_tx_phase #(
  parameter int unsigned CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    phase_end = !clr && (cnt_q == LAST);
    cnt_d     = cnt_q + 8'd1;
    if (clr || phase_end) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_frame_tx.sv
// SPI-mode-0 transmitter for the 96-bit clock-number frame, MSB first.
// Optional chip select enabled by CLOCK_FRAME_TX_CS_EN.
module clock_frame_tx
  import clock_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 24,
  parameter int unsigned FRAME_BYTES = 12
) (
  input  logic             clk,
  input  logic             reset,
  clock_frame_tx_if.master bus
);

  localparam logic [6:0] LAST_BIT = 7'(FRAME_BYTES * 8);

  tx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] packed_nums;
  logic [6:0]            bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_n_q, cs_n_d;
  logic                  phase_end;
  logic                  phase_clr;

  assign packed_nums = pack_frame(bus.nums);
  // timer sits at zero outside a frame so SETUP always gets a full half-period
  assign phase_clr   = (state_q == IDLE) || (state_q == DONE);

  clock_frame_tx_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (clk),
    .reset     (reset),
    .clr       (phase_clr),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cs_n_d    = cs_n_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SETUP;
          frame_d   = packed_nums;
          bit_cnt_d = 7'd0;
          sdo_d     = packed_nums[FRAME_BITS-1];
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
        end
      end
      SETUP, LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          sck_d   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d     = 1'b0;
          bit_cnt_d = bit_cnt_q + 7'd1;
          if (bit_cnt_d == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            // next bit goes out together with the falling sck edge
            state_d = LOW;
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            sdo_d   = frame_q[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_d = DONE;
          sdo_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cs_n_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= 7'd0;
      sck_q     <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign bus.sck  = sck_q;
  assign bus.sdo  = sdo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef CLOCK_FRAME_TX_CS_EN
  assign bus.cs_n = cs_n_q;
`else
  logic unused_cs;
  assign unused_cs = cs_n_q;
`endif

endmodule

// File: tb/tb_clock_frame_tx.sv
// Scoreboard bench for clock_frame_tx at CLK_DIV=2 with an sck-edge receiver model.
module tb_clock_frame_tx;
  import clock_frame_pkg::*;

  logic clk;
  logic rst_n;
  clock_frame_tx_if bus();

  clock_frame_tx #(.CLK_DIV(2), .FRAME_BYTES(12)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] model_frame(input clock_nums_t n);
    logic [95:0] f;
    f = '0;
    for (int i = 0; i < 12; i++) f = {f[87:0], 4'h0, n[i]};
    return f;
  endfunction

  logic [95:0] rx = '0;
  always @(posedge bus.sck) rx <= {rx[94:0], bus.sdo};

  logic [95:0] sbq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   base;
  int   rises, dones, busy_cyc, viol, first_rise, done_rel;
  int   idle_run, last_gap, cs_fall, cs_rise;
  bit   after_done;
  logic rise0_sdo;
  logic sck_p = 1'b0, sdo_p = 1'b0, busy_p = 1'b0, cs_p = 1'b1;

  task automatic clear_stats();
    rises = 0; dones = 0; busy_cyc = 0; viol = 0;
    first_rise = -1; done_rel = -1; rise0_sdo = 1'bx;
    idle_run = 0; last_gap = -1; after_done = 0;
    cs_fall = -1; cs_rise = -1;
  endtask

  always @(negedge clk) begin
    if (bus.sck && !sck_p) begin
      rises++;
      if (first_rise < 0) begin first_rise = cyc - base; rise0_sdo = bus.sdo; end
    end
    if (sck_p && bus.sck && (bus.sdo !== sdo_p)) viol++;
    if (bus.busy) busy_cyc++;
    if (after_done && bus.busy && !busy_p) begin last_gap = idle_run; after_done = 0; end
    if (after_done && !bus.busy && !bus.done && !bus.sck) idle_run++;
    if (bus.done) begin
      dones++;
      done_rel   = cyc - base;
      after_done = 1;
      idle_run   = 0;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else                 chk("sb_frame", rx, sbq.pop_front());
    end
`ifdef CLOCK_FRAME_TX_CS_EN
    if (cs_p && !bus.cs_n && cs_fall < 0) cs_fall = cyc - base;
    if (!cs_p && bus.cs_n) cs_rise = cyc - base;
    cs_p = bus.cs_n;
`endif
    sck_p  = bus.sck;
    sdo_p  = bus.sdo;
    busy_p = bus.busy;
  end

  // start is driven at a negedge; that cycle is cycle 0 relative to base
  task automatic send(input clock_nums_t n, input bit hold);
    @(negedge clk);
    bus.nums  = n;
    bus.start = 1'b1;
    base      = cyc;
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clk);
      t++;
      if (bus.done) seen++;
    end
    if (seen < n) chk("done_timeout", 0, 1);
  endtask

  clock_nums_t asc, fs, rnd, rnd2, rnd3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.nums  = '0;
    base = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_sck", bus.sck, 0);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
`ifdef CLOCK_FRAME_TX_CS_EN
    chk("rst_cs_n", bus.cs_n, 1);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ascending pattern with timing
    for (int i = 0; i < 12; i++) asc[i] = 4'(i + 1);
    chk("asc_model", model_frame(asc), 96'h01_02_03_04_05_06_07_08_09_0A_0B_0C);
    clear_stats();
    sbq.push_back(model_frame(asc));
    send(asc, 0);
    wait_done(1, 2000);
    @(negedge clk);
    chk("asc_rx_literal", rx, 96'h01_02_03_04_05_06_07_08_09_0A_0B_0C);
    chk("asc_rises", rises, 96);
    chk("asc_busy_cycles", busy_cyc, 386);
    chk("first_rise_cycle", first_rise, 3);
    chk("first_rise_sdo", rise0_sdo, 0);
    chk("done_cycle", done_rel, 387);
    chk("sdo_stable_high", viol, 0);
`ifdef CLOCK_FRAME_TX_CS_EN
    chk("cs_fall_cycle", cs_fall, 1);
    chk("cs_rise_cycle", cs_rise, 387);
    repeat (5) @(negedge clk);
    chk("cs_idle_high", bus.cs_n, 1);
`endif

    // start while busy is dropped; nums change mid-frame is ignored
    for (int i = 0; i < 12; i++) begin
      rnd[i]  = 4'($urandom_range(0, 15));
      rnd2[i] = ~rnd[i];
    end
    clear_stats();
    sbq.push_back(model_frame(rnd));
    send(rnd, 0);
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    bus.nums  = rnd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, 2000);
    repeat (500) @(negedge clk);
    chk("busy_start_rises", rises, 96);
    chk("busy_start_dones", dones, 1);
    chk("busy_start_viol", viol, 0);

    // start held high: back-to-back frames, one idle cycle between
    for (int i = 0; i < 12; i++) fs[i] = 4'hF;
    clear_stats();
    sbq.push_back(model_frame(fs));
    sbq.push_back(model_frame(fs));
    send(fs, 1);
    wait_done(2, 4000);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_rx_0f", rx, {12{8'h0F}});
    chk("held_rises", rises, 192);
    chk("held_dones", dones, 2);
    chk("held_idle_gap", last_gap, 1);

    // reset mid-frame aborts with no done
    for (int i = 0; i < 12; i++) rnd3[i] = 4'($urandom_range(0, 15));
    clear_stats();
    send(rnd, 0);
    repeat (149) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sck", bus.sck, 0);
    chk("abort_sdo", bus.sdo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
`ifdef CLOCK_FRAME_TX_CS_EN
    chk("abort_cs_n", bus.cs_n, 1);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("abort_no_done", dones, 0);
    clear_stats();
    sbq.push_back(model_frame(rnd3));
    send(rnd3, 0);
    wait_done(1, 2000);
    @(negedge clk);
    chk("post_reset_rises", rises, 96);
    chk("post_reset_done_cycle", done_rel, 387);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_frame_tx.md
# clock_frame_tx

Serial transmitter for the 96-bit clock-number frame. It is the SPI master end of the link whose slave end is the FPGA clock display's sck/sdi shift register. It takes twelve 4-bit clock numbers, packs them one per byte, and shifts them out MSB first on sck/sdo. It runs on the 48 MHz system clock and is used in the MCU-replacement test harness and in the loopback bring-up build.

## Interface
Parameters:
- CLK_DIV, 24: system clocks per sck half-period. The default gives 1 MHz sck from 48 MHz. Legal range is 1..255.
- FRAME_BYTES, 12: number of bytes per frame. Frame length is FRAME_BYTES*8 = 96 bits.

Ports:
- clk, input, 1: system clock, 48 MHz.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request to send one frame. Sampled only in IDLE.
- nums, input, 12x4 (packed [11:0][3:0]): clock numbers. nums[0] is the 1 o'clock position and nums[11] is the 12 o'clock position.
- sck, output, 1: serial clock. Idles low (SPI mode 0).
- sdo, output, 1: serial data. Changes only while sck is low.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the frame is complete.
- cs_n, output, 1: chip select. Present only under CLOCK_FRAME_TX_CS_EN.

## Operation
- Frame packing, on the cycle start is accepted: frame[95:0] = {4'h0,nums[0], 4'h0,nums[1], …, 4'h0,nums[11]}. frame[95] is sent first.
- nums is latched at acceptance. Later changes to nums do not affect a frame in flight.
- States: IDLE → SETUP → HIGH ⇄ LOW → HOLD → DONE → IDLE.
- IDLE:
  - sck=0, sdo=0, busy=0.
  - start=1 → latch frame, bit counter=0, go to SETUP.
- SETUP:
  - Lasts CLK_DIV cycles; sdo=frame[95], sck=0.
  - Then go to HIGH.
- HIGH:
  - Lasts CLK_DIV cycles with sck=1. The receiver samples sdo on this rising edge.
  - At exit, increment the bit counter.
  - If counter==96, go to HOLD; otherwise go to LOW.
- LOW:
  - Shift frame left by one on entry, so sdo = next bit.
  - Lasts CLK_DIV cycles with sck=0, then go to HIGH.
- HOLD:
  - Lasts CLK_DIV cycles; sck=0, sdo holds the last bit.
- DONE:
  - One cycle; done=1, busy=0, sdo=0.
  - start is ignored in this state. Go to IDLE.
- start asserted in any state other than IDLE is dropped, not queued.
- If start is held high continuously, the next frame is accepted on the first IDLE cycle, giving one IDLE cycle between frames.
- Half-period counter: 8 bits; counts 0..CLK_DIV-1, then wraps to 0 on each phase change.
- Bit counter: 7 bits; counts 0..96.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, sck=0, sdo=0, busy=0, done=0, cs_n=1, counters=0, frame register=0.
- Reset asserted mid-frame aborts the frame immediately with no done pulse. The receiver keeps a partial shift; a full frame is required to resynchronise.
- Start accepted at edge t:
  - busy=1, sdo=frame[95] from t+1.
  - First sck rise at t+1+CLK_DIV.
  - k-th rise (k=1..96) at t+1+CLK_DIV·(2k−1).
  - sdo changes at t+1+CLK_DIV·2k for k=1..95. This is simultaneous with sck falling, and data is stable for the whole high phase.
  - done=1 during cycle t+1+193·CLK_DIV; busy=0 from that cycle.
- Registered outputs only. No combinational path from start or nums to any output.

## Configuration
CLOCK_FRAME_TX_CS_EN:
- Defined:
  - cs_n port exists.
  - cs_n goes low with busy (cycle t+1) and returns high in the DONE cycle.
  - SETUP and HOLD then act as CS setup/hold guards of CLK_DIV cycles each.
- Undefined:
  - No cs_n port and no CS logic.
  - Behaviour is otherwise identical: same state sequence and timing.

## Structure
- Shared package clock_frame_pkg:
  - typedef clock_num_t (logic [3:0]).
  - typedef clock_nums_t (clock_num_t [11:0]).
  - localparam FRAME_BITS = 96.
  - tx_state_t enum {IDLE, SETUP, HIGH, LOW, HOLD, DONE}.
  - Function pack_frame(clock_nums_t) → logic [95:0].
- One sub-module, clock_frame_tx_phase: the half-period counter. It takes CLK_DIV, clears on start, and emits a one-cycle phase_end strobe. The FSM and shifter stay in the top module.

## Test plan
All scenarios use CLK_DIV=2. The bench contains an sck-posedge shift-register model of the receiver.
- Ascending pattern: nums[i]=i+1, start pulse → after done, receiver model holds 96'h01_02_03_04_05_06_07_08_09_0A_0B_0C; exactly 96 sck rises; busy high for 386 cycles.
- Timing check: start at cycle 0 → first sck rise at cycle 3, sdo=0 at that rise; sdo never changes while sck=1; done at cycle 387.
- Start while busy: pulse start at cycles 0 and 100 → exactly one frame, 96 rises, one done pulse.
- Start held high with nums=all 4'hF → back-to-back frames, exactly one IDLE cycle (sck=0, busy=0) between done and the next busy; each frame yields bytes 0x0F.
- Reset mid-frame: drop reset at cycle 150 → same cycle sck=0, sdo=0, busy=0, no done; next start sends a clean full frame.
- With CLOCK_FRAME_TX_CS_EN: cs_n falls at cycle 1, rises at cycle 387, and stays high when idle and after reset.
